// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: screen geometry, pipe sizes,
// LFSR constants and the pipe scroller state encoding.
package flappy_pkg;

   localparam int COORD_W  = 11;
   localparam int SCREEN_W = 800;
   localparam int SCREEN_H = 600;
   localparam int PIPE_W   = 72;
   localparam int GAP_H    = 200;

   // Left-shifting Fibonacci LFSR: x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      UPDATE  = 2'd2,
      STOPPED = 2'd3
   } state_t;

endpackage

// File: rtl/gap_lfsr.sv
// Free-running 16-bit LFSR that supplies pseudo-random gap heights.
// Only rst seeds it, so player timing between restarts adds entropy.
module gap_lfsr
   import flappy_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= LFSR_SEED;
      end else begin
         q <= {q[14:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/pipe_scroller.sv
// Moves three pipes left once per frame tick, one pipe per cycle through a
// shared subtract/wrap datapath, respawning wrapped pipes with a random gap.
module pipe_scroller
   import flappy_pkg::*;
#(
   parameter int SPEED           = 4,
   parameter int WRAP_SPAN       = 960,
   parameter int INIT_X0         = 880,
   parameter int INIT_X1         = 1200,
   parameter int INIT_X2         = 1520,
   parameter int GAP_BOT_DEFAULT = 400,
   parameter int GAP_BOT_MIN     = 250,
   parameter int BIRD_X          = 200
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               crash,
   input  logic               restart,
   output logic [COORD_W-1:0] bx,
   output logic [COORD_W-1:0] by,
   output logic [COORD_W-1:0] bx2,
   output logic [COORD_W-1:0] by2,
   output logic [COORD_W-1:0] bx3,
   output logic [COORD_W-1:0] by3,
   output logic               busy,
   output logic               score_tick
);

   localparam logic [COORD_W-1:0] SPEED_C  = COORD_W'(SPEED);
   localparam logic [COORD_W-1:0] WRAP_ADD = COORD_W'(WRAP_SPAN - SPEED);
   localparam logic [COORD_W-1:0] GAP_MIN  = COORD_W'(GAP_BOT_MIN);
   localparam logic [COORD_W-1:0] GAP_DEF  = COORD_W'(GAP_BOT_DEFAULT);
   localparam logic [COORD_W-1:0] BIRD_C   = COORD_W'(BIRD_X);
   localparam logic [COORD_W-1:0] X0_C     = COORD_W'(INIT_X0);
   localparam logic [COORD_W-1:0] X1_C     = COORD_W'(INIT_X1);
   localparam logic [COORD_W-1:0] X2_C     = COORD_W'(INIT_X2);

   state_t             state, state_nx;
   logic [1:0]         idx, idx_nx;
   logic               crash_pending, crash_pending_nx;
   logic               do_update;
   logic [COORD_W-1:0] px [3];
   logic [COORD_W-1:0] py [3];
   logic [COORD_W-1:0] cur_x, new_x, new_y;
   logic               wrap, pass;
   logic [15:0]        lfsr_q;
   logic               unused_lfsr_hi;

   gap_lfsr u_gap_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   assign unused_lfsr_hi = ^lfsr_q[15:8];

   // Shared datapath for the pipe selected by idx
   always_comb begin
      cur_x = px[idx];
      wrap  = cur_x < SPEED_C;
      new_x = wrap ? cur_x + WRAP_ADD : cur_x - SPEED_C;
      new_y = wrap ? GAP_MIN + {3'b000, lfsr_q[7:0]} : py[idx];
      pass  = !wrap && (cur_x >= BIRD_C) && (new_x < BIRD_C);
   end

   always_comb begin
      state_nx         = state;
      idx_nx           = idx;
      crash_pending_nx = crash_pending;
      do_update        = 1'b0;
      if (restart) begin
         state_nx         = IDLE;
         idx_nx           = 2'd0;
         crash_pending_nx = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) state_nx = RUN;
            end
            RUN: begin
               if (crash) begin
                  state_nx = STOPPED;
               end else if (frame_tick) begin
                  state_nx = UPDATE;
                  idx_nx   = 2'd0;
               end
            end
            UPDATE: begin
               do_update = 1'b1;
               if (crash) crash_pending_nx = 1'b1;
               if (idx == 2'd2) begin
                  // Crash seen anywhere in the sweep stops only once all pipes moved
                  state_nx         = (crash_pending || crash) ? STOPPED : RUN;
                  idx_nx           = 2'd0;
                  crash_pending_nx = 1'b0;
               end else begin
                  idx_nx = idx + 2'd1;
               end
            end
            default: state_nx = STOPPED;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= 2'd0;
         crash_pending <= 1'b0;
         busy          <= 1'b0;
         score_tick    <= 1'b0;
         px[0]         <= X0_C;
         px[1]         <= X1_C;
         px[2]         <= X2_C;
         py[0]         <= GAP_DEF;
         py[1]         <= GAP_DEF;
         py[2]         <= GAP_DEF;
      end else begin
         state         <= state_nx;
         idx           <= idx_nx;
         crash_pending <= crash_pending_nx;
         busy          <= (state_nx == UPDATE);
         score_tick    <= do_update && pass;
         if (restart) begin
            px[0] <= X0_C;
            px[1] <= X1_C;
            px[2] <= X2_C;
            py[0] <= GAP_DEF;
            py[1] <= GAP_DEF;
            py[2] <= GAP_DEF;
         end else if (do_update) begin
            px[idx] <= new_x;
            py[idx] <= new_y;
         end
      end
   end

   assign bx  = px[0];
   assign by  = py[0];
   assign bx2 = px[1];
   assign by2 = py[1];
   assign bx3 = px[2];
   assign by3 = py[2];

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: movement, wrap, scoring, crash, restart
// and asynchronous reset, with hand-computed expected positions.
module tb_pipe_scroller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        start = 1'b0;
   logic        crash = 1'b0;
   logic        restart = 1'b0;
   logic [10:0] bx, by, bx2, by2, bx3, by3;
   logic        busy, score_tick;

   int checks = 0;
   int errors = 0;

   logic [15:0] lfsr_ref;
   logic [2:0]  sc;
   logic [7:0]  rnd;

   always #5 clk = ~clk;

   pipe_scroller dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .start      (start),
      .crash      (crash),
      .restart    (restart),
      .bx         (bx),
      .by         (by),
      .bx2        (bx2),
      .by2        (by2),
      .bx3        (bx3),
      .by3        (by3),
      .busy       (busy),
      .score_tick (score_tick)
   );

   // Reference gap generator: x^16+x^14+x^13+x^11+1, shifting toward the MSB
   always @(posedge clk or posedge rst) begin
      if (rst) lfsr_ref <= 16'hACE1;
      else     lfsr_ref <= {lfsr_ref[14:0], lfsr_ref[15] ^ lfsr_ref[13] ^ lfsr_ref[12] ^ lfsr_ref[10]};
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One frame tick plus the three sweep cycles and one idle cycle
   task automatic sweep(output logic [2:0] s, output logic [7:0] r);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      r = lfsr_ref[7:0];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         s[k] = score_tick;
      end
      @(negedge clk);
   endtask

   task automatic cycle_in(input logic st, input logic cr, input logic ft, input logic rs);
      start = st; crash = cr; frame_tick = ft; restart = rs;
      @(negedge clk);
      start = 1'b0; crash = 1'b0; frame_tick = 1'b0; restart = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_bx",    bx, 880);
      chk("rst_bx2",   bx2, 1200);
      chk("rst_bx3",   bx3, 1520);
      chk("rst_by",    by, 400);
      chk("rst_by3",   by3, 400);
      chk("rst_busy",  busy, 0);
      chk("rst_score", score_tick, 0);

      // First move, stepped edge by edge
      cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
      cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
      chk("e0_busy", busy, 1);
      chk("e0_bx",   bx, 880);
      @(negedge clk);
      chk("e1_bx",   bx, 876);
      chk("e1_bx2",  bx2, 1200);
      chk("e1_busy", busy, 1);
      @(negedge clk);
      chk("e2_bx2",  bx2, 1196);
      chk("e2_bx3",  bx3, 1520);
      chk("e2_busy", busy, 1);
      @(negedge clk);
      chk("e3_bx3",  bx3, 1516);
      chk("e3_busy", busy, 0);
      chk("e3_by",   by, 400);
      chk("e3_by2",  by2, 400);
      chk("e3_by3",  by3, 400);
      @(negedge clk);

      // Ticks 2..221: score around the bird column, then the first wrap
      for (int t = 2; t <= 221; t++) begin
         sweep(sc, rnd);
         if (t == 170) chk("score_t170", sc, 3'b000);
         if (t == 171) begin
            chk("score_t171", sc, 3'b001);
            chk("bx_t171", bx, 196);
         end
         if (t == 172) chk("score_t172", sc, 3'b000);
         if (t == 220) begin
            chk("bx_t220",  bx, 0);
            chk("bx2_t220", bx2, 320);
            chk("bx3_t220", bx3, 640);
         end
      end
      chk("wrap_bx",    bx, 956);
      chk("wrap_by",    by, 250 + int'(rnd));
      chk("wrap_range", int'(by >= 11'd250 && by <= 11'd505), 1);
      chk("wrap_score", sc, 3'b000);
      chk("wrap_bx2",   bx2, 316);
      chk("wrap_by2",   by2, 400);

      // Crash after E1: sweep completes, then frozen
      cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("crash_e1_bx", bx, 952);
      cycle_in(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("crash_bx2",  bx2, 312);
      chk("crash_bx3",  bx3, 632);
      chk("crash_busy", busy, 0);
      for (int t = 0; t < 10; t++) sweep(sc, rnd);
      chk("stop_bx",   bx, 952);
      chk("stop_bx2",  bx2, 312);
      chk("stop_bx3",  bx3, 632);
      chk("stop_busy", busy, 0);

      // Restart from STOPPED, then restart mid-sweep
      cycle_in(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rs_bx", bx, 880);
      cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
      cycle_in(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("rsm_e1_bx", bx, 876);
      cycle_in(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rsm_bx",   bx, 880);
      chk("rsm_bx2",  bx2, 1200);
      chk("rsm_bx3",  bx3, 1520);
      chk("rsm_by",   by, 400);
      chk("rsm_by2",  by2, 400);
      chk("rsm_by3",  by3, 400);
      chk("rsm_busy", busy, 0);
      @(negedge clk);
      chk("rsm_abort_bx2", bx2, 1200);
      sweep(sc, rnd);
      chk("idle_tick_bx", bx, 880);

      // restart with start stays IDLE
      cycle_in(1'b1, 1'b0, 1'b0, 1'b1);
      sweep(sc, rnd);
      chk("rs_start_bx", bx, 880);

      // crash with frame_tick in RUN: no sweep, stopped
      cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
      cycle_in(1'b0, 1'b1, 1'b1, 1'b0);
      chk("cr_ft_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("cr_ft_bx", bx, 880);
      cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
      sweep(sc, rnd);
      chk("stop_start_bx", bx, 880);

      // LFSR keeps running across restart: second wrap matches the unreseeded reference
      cycle_in(1'b0, 1'b0, 1'b0, 1'b1);
      cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
      for (int t = 1; t <= 221; t++) sweep(sc, rnd);
      chk("wrap2_bx", bx, 956);
      chk("wrap2_by", by, 250 + int'(rnd));

      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      chk("arst_bx",   bx, 880);
      chk("arst_by",   by, 400);
      chk("arst_bx2",  bx2, 1200);
      chk("arst_bx3",  bx3, 1520);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Generates the three pipe positions (bx/by, bx2/by2, bx3/by3) consumed by the pipe painter. Each position uses the painter's coordinate convention: bx is the pipe's right-edge x, and by is the bottom y of the gap. On each frame tick while the game runs, the block moves all three pipes left in a three-cycle sequential sweep through one shared update datapath. Pipes leaving the left edge wrap to the right with a new pseudo-random gap height, and the block pulses a score tick when a pipe passes the bird column.

## Interface
Parameters:
- SPEED, 4: pixels moved per pipe per frame tick.
- WRAP_SPAN, 960: x distance added on wrap; three pipes at 320 spacing.
- INIT_X0 / INIT_X1 / INIT_X2, 880 / 1200 / 1520: start bx values, all off-screen right.
- GAP_BOT_DEFAULT, 400: start by value for every pipe.
- GAP_BOT_MIN, 250: minimum by on respawn.
- BIRD_X, 200: x column used for scoring.

Ports (clock and reset first):
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per frame, issued in vblank.
- start, in, 1: begin scrolling; honoured only in IDLE.
- crash, in, 1: collision detected; freeze pipes.
- restart, in, 1: return to initial layout, enter IDLE.
- bx, by, bx2, by2, bx3, by3, out, 11 each: pipe positions, registered.
- busy, out, 1: high while a sweep is in progress.
- score_tick, out, 1: one-cycle pulse per pipe passed.

## Operation
- States:
  - IDLE: positions held at init values. start moves to RUN.
  - RUN: frame_tick moves to UPDATE with idx=0. crash moves to STOPPED.
  - UPDATE: updates pipe idx on each cycle, for idx 0, 1, 2. After idx 2, moves to RUN, or to STOPPED if crash_pending is set.
  - STOPPED: positions frozen. Only restart leaves this state.
- Pipe update for pipe i, 11-bit unsigned arithmetic:
  - If bx_i < SPEED (wrap case): bx_i <= bx_i + WRAP_SPAN − SPEED, and by_i <= GAP_BOT_MIN + lfsr[7:0], giving a range of 250..505.
  - Otherwise: bx_i <= bx_i − SPEED.
  - The subtraction never underflows.
- Score: score_tick is asserted on the update edge when bx_i ≥ BIRD_X and the new bx_i < BIRD_X. This applies to the non-wrap case only.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1 on rst only.
  - Advances every clock in all states, so player timing adds entropy.
  - Not affected by restart.
- Reset and restart values:
  - bx=INIT_X0, bx2=INIT_X1, bx3=INIT_X2.
  - by, by2, by3 = GAP_BOT_DEFAULT.
  - busy=0, score_tick=0, crash_pending=0, state IDLE.
  - rst applies these asynchronously. restart applies them on the next edge.
- Priority and boundary cases:
  - restart beats every other input in every state, including mid-sweep; a sweep in progress is aborted.
  - restart together with start: the block stays in IDLE.
  - crash together with frame_tick in RUN: crash wins and no sweep starts.
  - crash during UPDATE: sets crash_pending. The sweep completes so all three pipes stay consistent, then the block goes to STOPPED.
  - frame_tick during UPDATE, IDLE or STOPPED: ignored.
  - start outside IDLE: ignored.

## Timing
- frame_tick is sampled at edge E0. busy is high for the 3 cycles after E0.
- Position updates:
  - bx/by update at E1.
  - bx2/by2 update at E2.
  - bx3/by3 update at E3.
  - busy falls at E3.
- score_tick is registered in the same edge as the pipe update that causes it and is high for exactly one cycle.
- Latency from start to RUN is 1 cycle. The first movement happens on the next frame_tick.
- All outputs come directly from registers; there is no combinational path from any input.

## Structure
- Shared package flappy_pkg holds:
  - COORD_W=11.
  - SCREEN_W=800, SCREEN_H=600.
  - PIPE_W=72, GAP_H=200, also used by the painter.
  - LFSR seed and taps.
  - The state enum {IDLE, RUN, UPDATE, STOPPED}.
- Sub-module gap_lfsr holds the 16-bit LFSR: clk, rst, and a 16-bit q output.
- The position registers form a 3-entry array indexed by idx, with one shared subtract/wrap datapath.

## Test plan
- Move: rst, start, one frame_tick → bx=876 at E1, bx2=1196 at E2, bx3=1516 at E3. busy is high 3 cycles. by values stay 400.
- Wrap: 221 frame_ticks → after tick 220, bx=0. Tick 221 sets bx=956 and by=250+lfsr[7:0], a value in 250..505, and no score_tick on that update.
- Score: tick 171 moves bx 200→196 → score_tick high for exactly one cycle, at E1 of that sweep. Ticks 170 and 172 produce no pulse.
- Crash mid-sweep: crash at E1+ε → bx2 and bx3 still update, then STOPPED. 10 further frame_ticks → no change.
- Restart mid-sweep: restart during UPDATE → next edge gives bx=880, bx2=1200, bx3=1520, all by=400, busy=0, IDLE. The LFSR continues without re-seeding.
- Async reset: rst asserted between edges → outputs return to init values immediately, with no clock edge required.
